// File: rtl/fwft_fifo_param.sv
// rtl/fwft_fifo_param.sv - parametrised first-word-fall-through FIFO with level, thresholds and flush
// Sticky overflow/underflow flags are built only when FWFT_FIFO_PARAM_ERR_FLAGS_EN is defined.
module fwft_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         rd_en_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("fwft_fifo_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fwft_fifo_param: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fwft_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fwft_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Explicit wrap at DEPTH-1 so non-power-of-2 depths never index past the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = wr_en_i & ~w_full  & ~flush_i;
  assign w_rd_acc = rd_en_i & ~w_empty & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; the level register alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign data_o         = r_mem[r_rd_ptr];
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_level >= LVL_W'(AF_THRESH));
  assign almost_empty_o = (r_level <= LVL_W'(AE_THRESH));
  assign level_o        = r_level;

`ifdef FWFT_FIFO_PARAM_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en_i & w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en_i & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fwft_fifo_param.sv
// tb/tb_fwft_fifo_param.sv - self-checking bench for fwft_fifo_param against a queue model
module tb_fwft_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int LW    = 3;
`ifdef FWFT_FIFO_PARAM_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full, empty, afull, aempty, ovf, unf;
  logic [LW-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  fwft_fifo_param #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr), .data_i(din),
    .rd_en_i(rd), .data_o(dout), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .almost_empty_o(aempty), .level_o(level),
    .overflow_o(ovf), .underflow_o(unf)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the queue model by what the FIFO should accept, settle past the edge.
  task automatic tick(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    int sz;
    wr = w; din = d; rd = r; flush = f;
    @(posedge clk);
    sz = q.size();
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0) m_unf = 1'b1;
      if (r && sz > 0) void'(q.pop_front());
      if (w && sz < DEPTH) q.push_back(d);
    end
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_tests++; if (aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b exp 1", aempty); end
    n_tests++; if (afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b exp 0", afull); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    n_tests++; if (unf !== 1'b0) begin n_fail++; $display("FAIL reset_unf got %b exp 0", unf); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      n_tests++; if (level !== LW'(i + 1)) begin n_fail++; $display("FAIL fill_level got %0d exp %0d", level, i + 1); end
      n_tests++; if (dout !== 8'h11) begin n_fail++; $display("FAIL fill_head got %h exp 11", dout); end
      n_tests++; if (aempty !== (i + 1 <= AE)) begin n_fail++; $display("FAIL fill_aempty level %0d got %b", i + 1, aempty); end
      n_tests++; if (afull !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_afull level %0d got %b", i + 1, afull); end
      n_tests++; if (full !== (i + 1 == DEPTH)) begin n_fail++; $display("FAIL fill_full level %0d got %b", i + 1, full); end
    end
    tick(1'b1, 8'h66, 1'b0, 1'b0);
    n_tests++; if (level !== 3'd5) begin n_fail++; $display("FAIL ovf_level got %0d exp 5", level); end
    n_tests++; if (ovf !== ERR_EN) begin n_fail++; $display("FAIL ovf_flag got %b exp %b", ovf, ERR_EN); end
    n_tests++; if (dout !== 8'h11) begin n_fail++; $display("FAIL ovf_head got %h exp 11", dout); end
  endtask

  task automatic test_wrap();
    while (q.size() > 0) tick(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b exp 1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (dout !== 8'(8'hA0 + i)) begin n_fail++; $display("FAIL wrap_data idx %0d got %h exp %h", i, dout, 8'(8'hA0 + i)); end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", empty); end
    n_tests++; if (unf !== 1'b0) begin n_fail++; $display("FAIL wrap_unf_early got %b exp 0", unf); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (unf !== ERR_EN) begin n_fail++; $display("FAIL unf_flag got %b exp %b", unf, ERR_EN); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL unf_level got %0d exp 0", level); end
  endtask

  task automatic test_simultaneous();
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b1, 8'h01, 1'b0, 1'b0);
    tick(1'b1, 8'h02, 1'b0, 1'b0);
    tick(1'b1, 8'h03, 1'b1, 1'b0);
    n_tests++; if (level !== 3'd2) begin n_fail++; $display("FAIL simul2_level got %0d exp 2", level); end
    n_tests++; if (dout !== 8'h02) begin n_fail++; $display("FAIL simul2_head got %h exp 02", dout); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (dout !== 8'h03) begin n_fail++; $display("FAIL simul2_order got %h exp 03", dout); end
    tick(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    tick(1'b1, 8'hBF, 1'b1, 1'b0);
    n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL simul5_level got %0d exp 4", level); end
    n_tests++; if (dout !== 8'hB1) begin n_fail++; $display("FAIL simul5_head got %h exp b1", dout); end
    while (q.size() > 0) tick(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (q[$] === 8'hBF) begin n_fail++; $display("FAIL model_sanity got bf"); end
    tick(1'b1, 8'h5A, 1'b1, 1'b0);
    n_tests++; if (level !== 3'd1) begin n_fail++; $display("FAIL simul0_level got %0d exp 1", level); end
    n_tests++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL simul0_head got %h exp 5a", dout); end
    n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL simul0_empty got %b exp 0", empty); end
  endtask

  task automatic test_flush();
    while (q.size() < DEPTH) tick(1'b1, 8'($urandom), 1'b0, 1'b0);
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL flush_pre_level got %0d exp 3", level); end
    n_tests++; if (ovf !== ERR_EN) begin n_fail++; $display("FAIL flush_pre_ovf got %b exp %b", ovf, ERR_EN); end
    tick(1'b1, 8'hEE, 1'b0, 1'b1);
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL flush_level got %0d exp 0", level); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b exp 1", empty); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got %b exp 0", ovf); end
    tick(1'b0, '0, 1'b0, 1'b0);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_nostore got %b exp 1", empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    wr = 1'b1; din = 8'hD3;
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_empty got %b exp 1", empty); end
    n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL arst_level got %0d exp 0", level); end
    wr = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1'b1, 8'hC1, 1'b0, 1'b0);
    tick(1'b1, 8'hC2, 1'b0, 1'b0);
    n_tests++; if (level !== 3'd2) begin n_fail++; $display("FAIL arst_new_level got %0d exp 2", level); end
    n_tests++; if (dout !== 8'hC1) begin n_fail++; $display("FAIL arst_new_head got %h exp c1", dout); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (dout !== 8'hC2) begin n_fail++; $display("FAIL arst_second got %h exp c2", dout); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_drained got %b exp 1", empty); end
  endtask

  task automatic test_random();
    int sz;
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 35;
      tick($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 63) == 0);
      sz = q.size();
      n_tests++; if (level !== LW'(sz)) begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", i, level, sz); end
      n_tests++; if (empty !== (sz == 0) || full !== (sz == DEPTH)) begin n_fail++; $display("FAIL rnd_ef cyc %0d got %b%b exp size %0d", i, empty, full, sz); end
      n_tests++; if (afull !== (sz >= AF) || aempty !== (sz <= AE)) begin n_fail++; $display("FAIL rnd_thr cyc %0d got af %b ae %b size %0d", i, afull, aempty, sz); end
      n_tests++; if (ovf !== (ERR_EN & m_ovf) || unf !== (ERR_EN & m_unf)) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", i, ovf, unf, ERR_EN & m_ovf, ERR_EN & m_unf); end
      if (sz > 0) begin
        n_tests++; if (dout !== q[0]) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, dout, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwft_fifo_param.md
Name: fwft_fifo_param

Overview:
- Parametrised successor of the team's first-word-fall-through FIFO, with generalised width and depth.
- Adds: non-power-of-2 depth support, occupancy level output, programmable almost-full/almost-empty thresholds, synchronous flush, and optional sticky overflow/underflow error flags.
- Single-clock buffer between a producer and a consumer inside one clock domain. The head word is always visible on data_o with no read latency.

Parameters:
- DATA_WIDTH, 8, bits per entry; must be >= 1.
- DEPTH, 4, number of entries; must be >= 2; need not be a power of 2.
- AF_THRESH, DEPTH-1, almost_full_o asserts when level >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty_o asserts when level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of FIFO contents.
- wr_en_i  in  1  write request.
- data_i  in  DATA_WIDTH  write data.
- rd_en_i  in  1  read/pop request; pops the word currently on data_o.
- data_o  out  DATA_WIDTH  head-of-queue data (FWFT).
- full_o  out  1  level == DEPTH.
- empty_o  out  1  level == 0.
- almost_full_o  out  1  level >= AF_THRESH.
- almost_empty_o  out  1  level <= AE_THRESH.
- level_o  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: wr_ptr=0, rd_ptr=0, level_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0. Memory is not reset.
- Reset mid-operation: outputs take their reset values immediately (asynchronously); all stored contents are discarded.
- Write acceptance: wr_acc = wr_en_i & ~full_o & ~flush_i. On acceptance, mem[wr_ptr] <= data_i and wr_ptr advances.
- Read acceptance: rd_acc = rd_en_i & ~empty_o & ~flush_i. On acceptance, rd_ptr advances.
- Pointer wrap: both pointers are $clog2(DEPTH) bits wide (minimum 1). A pointer equal to DEPTH-1 wraps to 0 explicitly; plain modulo-2^n rollover is not permitted.
- Level update:
  - wr_acc only: level +1.
  - rd_acc only: level -1.
  - both: level unchanged.
  - neither: unchanged.
- Simultaneous events:
  - Full with wr_en_i and rd_en_i: only the read is accepted; level becomes DEPTH-1; the write is dropped.
  - Empty with both asserted: only the write is accepted; level becomes 1. No bypass: data_o shows the new word from the next cycle.
- FWFT timing:
  - data_o = mem[rd_ptr], combinational from registered state.
  - The first word written into an empty FIFO appears on data_o and empty_o drops in the cycle after the write edge.
  - data_o is don't-care while empty_o=1.
- Flags: all flags are combinational decodes of the registered level. No flag has extra latency beyond the level register.
- Flush: when flush_i=1 at a clock edge:
  - pointers and level go to 0 and error flags clear;
  - wr_en_i and rd_en_i in that cycle are ignored;
  - flush has priority over every other action.
- Error flags (when the feature is enabled):
  - overflow_o sets on any edge with wr_en_i & full_o & ~flush_i.
  - underflow_o sets on any edge with rd_en_i & empty_o & ~flush_i.
  - Both hold until reset or flush.
- Parameter checks: illegal parameter values cause an elaboration-time $error.

Optional Feature:
- Macro: FWFT_FIFO_PARAM_ERR_FLAGS_EN.
- Defined: overflow_o/underflow_o behave as described above.
- Undefined: both ports remain present but are tied to constant 0, and no error-flag logic is instantiated.
- All other behaviour is identical in both builds.

Test Plan:
Configuration for all scenarios: DATA_WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1, macro defined.
- Reset, then idle -> empty_o=1, full_o=0, level_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0.
- Write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles:
  - data_o=0x11 one cycle after the first write;
  - almost_empty_o drops at level 2;
  - almost_full_o rises at level 4;
  - full_o=1 and level_o=5 after the 5th write.
  - A 6th write of 0x66 -> dropped, level_o stays 5, overflow_o=1.
- Non-power-of-2 wrap:
  - Write 3 words, read 3 words, then write 0xA0..0xA4 (pointers wrap past index 4).
  - Then read 5 -> data_o sequence 0xA0,0xA1,0xA2,0xA3,0xA4; then empty_o=1.
  - One further rd_en_i -> underflow_o=1, level_o stays 0.
- Simultaneous rd/wr:
  - At level 2 -> level stays 2 and order is preserved.
  - At level 5 -> read accepted, write dropped, level_o=4.
  - At level 0 -> write accepted, level_o=1, data_o=written value on the next cycle.
- Flush at level 3 with wr_en_i=1 and overflow_o=1 -> next cycle level_o=0, empty_o=1, overflow_o=0, and the write is not stored.
- Assert rst_ni low mid-burst at level 3, asynchronously between clock edges -> empty_o=1 and level_o=0 before the next edge. After release, the FIFO accepts new data starting at 0 with no stale words.
